demod_stage: RTL

DEMOD_STAGE -- requirements
Module: demod_stage

---
 rtl/demod_pkg.sv | 52 +++++
 rtl/demod_slicer.sv | 49 ++++
 rtl/demod_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/demod_pkg.sv
// rtl/demod_pkg.sv - shared encodings, thresholds and constellation levels for demod_stage.
`ifndef CONS_SCALE_SHIFT
`define CONS_SCALE_SHIFT 10
`endif

package demod_pkg;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_16QAM = 2'd2,
    MOD_64QAM = 2'd3
  } mod_t;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SYMBOL = 1'b1
  } state_t;

  localparam int SCALE = 1 << `CONS_SCALE_SHIFT;
  localparam int N48   = 48;
  localparam int N52   = 52;

  // Reciprocal square roots in Q20, so every level is round(k * SCALE / sqrt(d)).
  localparam longint INV_SQRT2_Q20  = 741455;
  localparam longint INV_SQRT10_Q20 = 331588;
  localparam longint INV_SQRT42_Q20 = 161799;

  function automatic logic [15:0] scale_q20(input int k, input longint inv);
    return 16'((longint'(k) * longint'(SCALE) * inv + 64'sd524288) >>> 20);
  endfunction

  localparam logic [15:0] T16    = scale_q20(2, INV_SQRT10_Q20);
  localparam logic [15:0] T64_2  = scale_q20(2, INV_SQRT42_Q20);
  localparam logic [15:0] T64_4  = scale_q20(4, INV_SQRT42_Q20);
  localparam logic [15:0] T64_6  = scale_q20(6, INV_SQRT42_Q20);

  localparam logic [15:0] L64_1  = scale_q20(1, INV_SQRT42_Q20);
  localparam logic [15:0] L64_3  = scale_q20(3, INV_SQRT42_Q20);
  localparam logic [15:0] L64_5  = scale_q20(5, INV_SQRT42_Q20);
  localparam logic [15:0] L64_7  = scale_q20(7, INV_SQRT42_Q20);
  localparam logic [15:0] L16_1  = scale_q20(1, INV_SQRT10_Q20);
  localparam logic [15:0] L16_3  = scale_q20(3, INV_SQRT10_Q20);
  localparam logic [15:0] L_QPSK = scale_q20(1, INV_SQRT2_Q20);
  localparam logic [15:0] L_BPSK = 16'(SCALE);

  // Magnitude of a two's-complement axis value; the most negative code clips to +max.
  function automatic logic [15:0] sat_abs(input logic [15:0] x);
    return x[15] ? ((x == 16'h8000) ? 16'h7fff : (~x + 16'd1)) : x;
  endfunction

endpackage

// File: rtl/demod_slicer.sv
// rtl/demod_slicer.sv - per-axis hard slicer: magnitude and sign to up to three Gray bits.
// With DEMOD_EVM_EN it also reports the magnitude of the chosen constellation level.
module demod_slicer
  import demod_pkg::*;
(
  input  logic [15:0] mag,
  input  logic        neg,
  input  mod_t        mode,
  output logic [2:0]  bits
`ifdef DEMOD_EVM_EN
  ,
  output logic [15:0] ref_mag
`endif
);

  always_comb begin
    bits    = 3'b000;
    bits[0] = ~neg;
    case (mode)
      MOD_16QAM: bits[1] = (mag < T16);
      MOD_64QAM: begin
        bits[1] = (mag < T64_4);
        bits[2] = (mag > T64_2) && (mag < T64_6);
      end
      default: ;
    endcase
  end

`ifdef DEMOD_EVM_EN
  // Level follows the decision, so threshold ties resolve to an equidistant point.
  always_comb begin
    ref_mag = L_BPSK;
    case (mode)
      MOD_QPSK:  ref_mag = L_QPSK;
      MOD_16QAM: ref_mag = bits[1] ? L16_1 : L16_3;
      MOD_64QAM: begin
        case (bits[2:1])
          2'b01:   ref_mag = L64_1;
          2'b11:   ref_mag = L64_3;
          2'b10:   ref_mag = L64_5;
          default: ref_mag = L64_7;
        endcase
      end
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/demod_stage.sv
// rtl/demod_stage.sv - two-stage hard-decision demapper with symbol framing.
// Define DEMOD_EVM_EN to add the per-symbol error accumulator ports evm_sum/evm_stb.
module demod_stage
  import demod_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] sample_in,
  input  logic        sample_in_strobe,
  input  logic [1:0]  mod_type,
  input  logic        ht,
  output logic [5:0]  bits_out,
  output logic        bits_out_strobe,
  output logic [5:0]  carrier_idx,
  output logic        symbol_done,
  output logic        state
`ifdef DEMOD_EVM_EN
  ,
  output logic [23:0] evm_sum,
  output logic        evm_stb
`endif
);

  localparam logic [5:0] LAST48 = 6'(N48 - 1);
  localparam logic [5:0] LAST52 = 6'(N52 - 1);

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  mod_t       mode_q, mode_d, eff_mode;
  logic       ht_q, ht_d, eff_ht;
  logic       last_carrier;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      mode_q  <= MOD_BPSK;
      ht_q    <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      ht_q    <= ht_d;
    end
  end

  // The first carrier of a symbol already uses the mode presented with it.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mode_d   = mode_q;
    ht_d     = ht_q;
    eff_mode = mode_q;
    eff_ht   = ht_q;
    if (state_q == S_IDLE) begin
      eff_mode = mod_t'(mod_type);
      eff_ht   = ht;
    end
    last_carrier = (count_q == (eff_ht ? LAST52 : LAST48));
    if (sample_in_strobe) begin
      mode_d = eff_mode;
      ht_d   = eff_ht;
      if (last_carrier) begin
        state_d = S_IDLE;
        count_d = '0;
      end else begin
        state_d = S_SYMBOL;
        count_d = count_q + 6'd1;
      end
    end
  end

  logic        s1_valid, s1_neg_i, s1_neg_q, s1_last;
  logic [15:0] s1_mag_i, s1_mag_q;
  mod_t        s1_mode;
  logic [5:0]  s1_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_neg_i <= 1'b0;
      s1_neg_q <= 1'b0;
      s1_mag_i <= '0;
      s1_mag_q <= '0;
      s1_mode  <= MOD_BPSK;
      s1_idx   <= '0;
      s1_last  <= 1'b0;
    end else if (enable) begin
      s1_valid <= sample_in_strobe;
      if (sample_in_strobe) begin
        s1_neg_i <= sample_in[31];
        s1_neg_q <= sample_in[15];
        s1_mag_i <= sat_abs(sample_in[31:16]);
        s1_mag_q <= sat_abs(sample_in[15:0]);
        s1_mode  <= eff_mode;
        s1_idx   <= count_q;
        s1_last  <= last_carrier;
      end
    end
  end

  logic [2:0] sl_i, sl_q;
  logic [5:0] bits_d;
`ifdef DEMOD_EVM_EN
  logic [15:0] ref_i, ref_q;
`endif

  demod_slicer u_slicer_i (
    .mag     (s1_mag_i),
    .neg     (s1_neg_i),
    .mode    (s1_mode),
`ifdef DEMOD_EVM_EN
    .ref_mag (ref_i),
`endif
    .bits    (sl_i)
  );

  demod_slicer u_slicer_q (
    .mag     (s1_mag_q),
    .neg     (s1_neg_q),
    .mode    (s1_mode),
`ifdef DEMOD_EVM_EN
    .ref_mag (ref_q),
`endif
    .bits    (sl_q)
  );

  always_comb begin
    bits_d = '0;
    case (s1_mode)
      MOD_BPSK:  bits_d = {5'b0, sl_i[0]};
      MOD_QPSK:  bits_d = {4'b0, sl_q[0], sl_i[0]};
      MOD_16QAM: bits_d = {2'b0, sl_q[1:0], sl_i[1:0]};
      default:   bits_d = {sl_q, sl_i};
    endcase
  end

  logic s2_valid, s2_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      bits_out    <= '0;
      carrier_idx <= '0;
    end else if (enable) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last     <= s1_last;
        bits_out    <= bits_d;
        carrier_idx <= s1_idx;
      end
    end
  end

  assign bits_out_strobe = enable & s2_valid;
  assign symbol_done     = enable & s2_valid & s2_last;
  assign state           = state_q;

`ifdef DEMOD_EVM_EN
  logic [15:0] ref_q_eff, err_i, err_q;
  logic [24:0] evm_next;
  logic [23:0] evm_acc;

  // Sign of the reference always matches the sample, so the distance is ||x| - level|.
  always_comb begin
    ref_q_eff = (s1_mode == MOD_BPSK) ? 16'd0 : ref_q;
    err_i     = (s1_mag_i >= ref_i) ? (s1_mag_i - ref_i) : (ref_i - s1_mag_i);
    err_q     = (s1_mag_q >= ref_q_eff) ? (s1_mag_q - ref_q_eff) : (ref_q_eff - s1_mag_q);
    evm_next  = ((s1_idx == 6'd0) ? 25'd0 : {1'b0, evm_acc}) + {9'd0, err_i} + {9'd0, err_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      evm_acc <= '0;
    end else if (enable && s1_valid) begin
      evm_acc <= evm_next[24] ? 24'hFFFFFF : evm_next[23:0];
    end
  end

  assign evm_sum = evm_acc;
  assign evm_stb = symbol_done;
`endif

endmodule
